// File: rtl/dff_debounce_edge_if.sv
// Level-conditioning bus for dff_debounce_edge: raw level and qualifier in,
// clean level, edge pulses and busy flag out.
interface dff_debounce_edge_if;
    logic en;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output en,
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  en,
        input  din,
        output dout,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/dff_debounce_edge.sv
// Synchronises and debounces a slow 1-bit level, producing a clean level,
// registered one-cycle rise/fall pulses and a busy flag while a change is timed.
module dff_debounce_edge #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic               clk,
    input  logic               reset,
    dff_debounce_edge_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       busy_q, busy_d;

    // Two-flop synchroniser inputs; free-running regardless of en.
    always_comb begin
        sync1_d = bus.din;
        sync2_d = sync1_q;
    end

    // State register: synchroniser, FSM state/counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; a disabled cycle freezes state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.en) begin
            case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync2_q) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (sync2_q) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // Output logic; pulses fire only on a WAIT -> STABLE accept transition.
    always_comb begin
        dout_d = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        rise_d = (state_q == WAIT_HI) && (state_d == STABLE_HI);
        fall_d = (state_q == WAIT_LO) && (state_d == STABLE_LO);
        busy_d = (state_q == WAIT_HI) || (state_q == WAIT_LO);
    end

    assign bus.dout = dout_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_dff_debounce_edge.sv
// Self-checking bench for dff_debounce_edge: a run-length reference model feeds
// a scoreboard queue, and scenario tasks check the documented timing points.
module tb_dff_debounce_edge;

    localparam int S = 4;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk;
    logic reset;
    dff_debounce_edge_if bus_if ();

    int   checks     = 0;
    int   failures   = 0;
    int   rise_seen  = 0;
    int   fall_seen  = 0;
    exp_t sb_q[$];
    exp_t m_exp;
    exp_t got;

    logic m_s1   = 1'b0;
    logic m_s2   = 1'b0;
    logic m_dout = 1'b0;
    int   m_run  = 0;

    dff_debounce_edge #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the level flips once S+1 consecutive enabled samples disagree with it.
    always @(posedge clk) begin
        if (!reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_dout = 1'b0; m_run = 0;
            m_exp = '0;
        end else begin
            m_exp.busy = (m_run != 0);
            m_exp.rise = 1'b0;
            m_exp.fall = 1'b0;
            if (bus_if.en) begin
                if (m_s2 != m_dout) begin
                    m_run = m_run + 1;
                    if (m_run == S + 1) begin
                        m_dout     = m_s2;
                        m_exp.rise = m_s2;
                        m_exp.fall = !m_s2;
                        m_run      = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus_if.din;
            m_exp.dout = m_dout;
        end
        sb_q.push_back(m_exp);
    end

    // Scoreboard: compare outputs shortly after each edge and tally pulses.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            checks++;
            if ({bus_if.dout, bus_if.rise, bus_if.fall, bus_if.busy} !== got) begin
                failures++;
                $display("FAIL scoreboard t=%0t dout/rise/fall/busy got=%b%b%b%b exp=%b",
                         $time, bus_if.dout, bus_if.rise, bus_if.fall, bus_if.busy, got);
            end
            checks++;
            if ((bus_if.rise & bus_if.fall) !== 1'b0) begin
                failures++;
                $display("FAIL rise_fall_exclusive t=%0t rise=%b fall=%b exp not both 1",
                         $time, bus_if.rise, bus_if.fall);
            end
            if (bus_if.rise === 1'b1) rise_seen++;
            if (bus_if.fall === 1'b1) fall_seen++;
        end
    end

    task automatic settle_low();
        bus_if.din = 1'b0;
        bus_if.en  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        int r0;
        reset = 1'b0; bus_if.din = 1'b1; bus_if.en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.dout, bus_if.rise, bus_if.fall, bus_if.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000",
                     {bus_if.dout, bus_if.rise, bus_if.fall, bus_if.busy});
        end
        r0 = rise_seen;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.dout !== (k >= 6)) begin
                failures++;
                $display("FAIL reset_release_dout edge=%0d got=%b exp=%b", k, bus_if.dout, (k >= 6));
            end
        end
        checks++;
        if (rise_seen - r0 !== 1) begin
            failures++;
            $display("FAIL reset_release_rises got=%0d exp=1", rise_seen - r0);
        end
    endtask

    task automatic test_clean_edges();
        int f0;
        bus_if.din = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.busy !== (k >= 3 && k <= 6)) begin
                failures++;
                $display("FAIL clean_busy edge=%0d got=%b exp=%b", k, bus_if.busy, (k >= 3 && k <= 6));
            end
            checks++;
            if ({bus_if.dout, bus_if.rise} !== {(k >= 6), (k == 6)}) begin
                failures++;
                $display("FAIL clean_rise edge=%0d dout/rise got=%b%b exp=%b%b",
                         k, bus_if.dout, bus_if.rise, (k >= 6), (k == 6));
            end
        end
        f0 = fall_seen;
        bus_if.din = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.fall !== (k == 6)) begin
                failures++;
                $display("FAIL clean_fall edge=%0d got=%b exp=%b", k, bus_if.fall, (k == 6));
            end
        end
        checks++;
        if (fall_seen - f0 !== 1) begin
            failures++;
            $display("FAIL clean_fall_count got=%0d exp=1", fall_seen - f0);
        end
    endtask

    task automatic test_glitch();
        int  r0;
        int  f0;
        bit  busy_hit;
        busy_hit = 1'b0;
        r0 = rise_seen;
        bus_if.din = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) bus_if.din = 1'b0;
            @(negedge clk);
            if (bus_if.busy === 1'b1) busy_hit = 1'b1;
        end
        checks++;
        if ({busy_hit, bus_if.busy, bus_if.dout} !== 3'b100) begin
            failures++;
            $display("FAIL glitch_short busy_hit/busy/dout got=%b%b%b exp=100",
                     busy_hit, bus_if.busy, bus_if.dout);
        end
        checks++;
        if (rise_seen - r0 !== 0) begin
            failures++;
            $display("FAIL glitch_short_rises got=%0d exp=0", rise_seen - r0);
        end
        r0 = rise_seen;
        f0 = fall_seen;
        bus_if.din = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) bus_if.din = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({rise_seen - r0, fall_seen - f0} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL glitch_min_width rises/falls got=%0d/%0d exp=1/1",
                     rise_seen - r0, fall_seen - f0);
        end
    endtask

    task automatic test_enable();
        int  r0;
        int  n_en;
        logic en_k;
        r0 = rise_seen;
        n_en = 0;
        bus_if.din = 1'b1;
        for (int k = 0; k < 20; k++) begin
            en_k = (((k >> 1) & 1) == 0);
            bus_if.en = en_k;
            @(negedge clk);
            if (en_k && k >= 2) n_en++;
            checks++;
            if (bus_if.dout !== (n_en >= S + 1)) begin
                failures++;
                $display("FAIL enable_dout edge=%0d got=%b exp=%b", k, bus_if.dout, (n_en >= S + 1));
            end
            if (!en_k) begin
                checks++;
                if ({bus_if.rise, bus_if.fall} !== 2'b00) begin
                    failures++;
                    $display("FAIL enable_pulse_gated edge=%0d rise/fall got=%b%b exp=00",
                             k, bus_if.rise, bus_if.fall);
                end
            end
        end
        bus_if.en = 1'b1;
        checks++;
        if (rise_seen - r0 !== 1) begin
            failures++;
            $display("FAIL enable_rises got=%0d exp=1", rise_seen - r0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int r0;
        bus_if.din = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dut.cnt_q !== 3'd2) begin
            failures++;
            $display("FAIL midwait_cnt_before got=%0d exp=2", dut.cnt_q);
        end
        r0 = rise_seen;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({dut.state_q, dut.cnt_q, bus_if.dout, bus_if.busy, bus_if.rise} !== 8'b00_000_000) begin
            failures++;
            $display("FAIL midwait_reset state/cnt/dout/busy/rise got=%b exp=00000000",
                     {dut.state_q, dut.cnt_q, bus_if.dout, bus_if.busy, bus_if.rise});
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (bus_if.dout !== (k >= 6)) begin
                failures++;
                $display("FAIL midwait_requalify edge=%0d got=%b exp=%b", k, bus_if.dout, (k >= 6));
            end
        end
        checks++;
        if (rise_seen - r0 !== 1) begin
            failures++;
            $display("FAIL midwait_rises got=%0d exp=1", rise_seen - r0);
        end
    endtask

    task automatic test_bounce();
        int r0;
        int f0;
        r0 = rise_seen;
        f0 = fall_seen;
        for (int k = 0; k < 40; k++) begin
            bus_if.din = (((k >> 1) & 1) == 0);
            @(negedge clk);
        end
        checks++;
        if ({rise_seen - r0, fall_seen - f0} !== {32'd0, 32'd0}) begin
            failures++;
            $display("FAIL bounce_train rises/falls got=%0d/%0d exp=0/0",
                     rise_seen - r0, fall_seen - f0);
        end
        bus_if.din = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if ({rise_seen - r0, fall_seen - f0, 31'd0, bus_if.dout} !== {32'd1, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL bounce_hold rises/falls/dout got=%0d/%0d/%b exp=1/0/1",
                     rise_seen - r0, fall_seen - f0, bus_if.dout);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus_if.en = 1'b1;
        bus_if.din = 1'b0;
        test_reset();
        settle_low();
        test_clean_edges();
        settle_low();
        test_glitch();
        settle_low();
        test_enable();
        settle_low();
        test_reset_mid_wait();
        settle_low();
        test_bounce();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
